multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RISC-V control FSM with ALU decoder, trap flag and retire pulse
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic       instr_done
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER,
        EXECUTEI, ALUWB, BRANCH, JAL, LUI, TRAP
    } state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

    state_t state, next_state;
    aluop_t alu_op;
    logic   ir_w, pc_w, reg_w, mem_w, done;

    // state register; async reset returns to FETCH even from TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    // sticky illegal flag, set as the FSM enters TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal <= 1'b0;
        else        illegal <= illegal | (next_state == TRAP);
    end

    // next-state and per-state datapath controls
    always_comb begin
        next_state = state;
        alu_op     = ALU_ADD;
        ImmSrc     = 3'b000;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        done       = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_w       = mem_ready;
                pc_w       = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                case (op)
                    7'b0000011, 7'b0100011: next_state = MEMADR;
                    7'b0110011:             next_state = EXECUTER;
                    7'b0010011:             next_state = EXECUTEI;
                    7'b1100011:             next_state = BRANCH;
                    7'b1101111:             next_state = JAL;
                    7'b0110111:             next_state = LUI;
                    default:                next_state = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = op[5] ? 3'b001 : 3'b000;
                next_state = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                reg_w      = 1'b1;
                done       = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_w      = 1'b1;
                done       = mem_ready;
                next_state = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALU_FUNCT;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = ALU_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_w      = 1'b1;
                done       = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALU_SUB;
                pc_w       = zero ^ funct3[0];
                done       = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                ImmSrc     = 3'b011;
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_w       = 1'b1;
                next_state = ALUWB;
            end
            LUI: begin
                ImmSrc     = 3'b100;
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                next_state = ALUWB;
            end
            TRAP:    next_state = TRAP;
            default: next_state = FETCH;
        endcase
    end

    // ALU decoder: subtract only for R-type with funct7[5] set
    always_comb begin
        ALUControl = 3'b000;
        if (alu_op == ALU_SUB) ALUControl = 3'b001;
        else if (alu_op == ALU_FUNCT)
            case (funct3)
                3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                3'b010:  ALUControl = 3'b101;
                3'b110:  ALUControl = 3'b011;
                3'b111:  ALUControl = 3'b010;
                default: ALUControl = 3'b000;
            endcase
    end

    // enables are masked while reset is held, since FETCH would otherwise follow mem_ready
    assign IRWrite    = ir_w  & rst_n;
    assign PCWrite    = pc_w  & rst_n;
    assign RegWrite   = reg_w & rst_n;
    assign MemWrite   = mem_w & rst_n;
    assign instr_done = done  & rst_n;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle checks of every controller output
module tb_multicycle_controller;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [2:0] ImmSrc, ALUControl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal, instr_done;
    int         compared = 0, mismatched = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .ALUControl(ALUControl), .illegal(illegal), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // ImmSrc|ALUSrcA|ALUSrcB|ResultSrc|AdrSrc|IRWrite|PCWrite|RegWrite|MemWrite|ALUControl|illegal|instr_done
    logic [18:0] obs;
    assign obs = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite,
                  RegWrite, MemWrite, ALUControl, illegal, instr_done};

    localparam logic [18:0] FETCH1 = 19'b000_00_10_10_0_1_1_0_0_000_0_0;
    localparam logic [18:0] FETCH0 = 19'b000_00_10_10_0_0_0_0_0_000_0_0;
    localparam logic [18:0] DEC    = 19'b010_01_01_00_0_0_0_0_0_000_0_0;
    localparam logic [18:0] ADR_L  = 19'b000_10_01_00_0_0_0_0_0_000_0_0;
    localparam logic [18:0] ADR_S  = 19'b001_10_01_00_0_0_0_0_0_000_0_0;
    localparam logic [18:0] MRD    = 19'b000_00_00_00_1_0_0_0_0_000_0_0;
    localparam logic [18:0] MWB    = 19'b000_00_00_01_0_0_0_1_0_000_0_1;
    localparam logic [18:0] MWR0   = 19'b000_00_00_00_1_0_0_0_1_000_0_0;
    localparam logic [18:0] MWR1   = 19'b000_00_00_00_1_0_0_0_1_000_0_1;
    localparam logic [18:0] EXR    = 19'b000_10_00_00_0_0_0_0_0_000_0_0;
    localparam logic [18:0] EXI    = 19'b000_10_01_00_0_0_0_0_0_000_0_0;
    localparam logic [18:0] AWB    = 19'b000_00_00_00_0_0_0_1_0_000_0_1;
    localparam logic [18:0] BRT    = 19'b000_10_00_00_0_0_1_0_0_001_0_1;
    localparam logic [18:0] BRN    = 19'b000_10_00_00_0_0_0_0_0_001_0_1;
    localparam logic [18:0] JALV   = 19'b011_01_10_00_0_0_1_0_0_000_0_0;
    localparam logic [18:0] LUIV   = 19'b100_11_01_00_0_0_0_0_0_000_0_0;
    localparam logic [18:0] TRP    = 19'b000_00_00_00_0_0_0_0_0_000_1_0;

    task automatic test_reset();
        mem_ready = 1'b1;
        #2;
        compared++;
        if (obs !== FETCH0) begin
            mismatched++;
            $display("FAIL reset_ready obs=%b exp=%b", obs, FETCH0);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        compared++;
        if (obs !== FETCH0) begin
            mismatched++;
            $display("FAIL reset_idle obs=%b exp=%b", obs, FETCH0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [18:0] e [4] = '{FETCH1, DEC, EXR, AWB};
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL add cyc%0d obs=%b exp=%b", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw();
        logic [18:0] e [9] = '{FETCH0, FETCH0, FETCH1, DEC, ADR_L, MRD, MRD, MRD, MWB};
        bit          m [9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
        op = 7'b0000011; funct3 = 3'b010;
        for (int i = 0; i < 9; i++) begin
            mem_ready = m[i];
            #1;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL lw cyc%0d obs=%b exp=%b", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [18:0] e [6] = '{FETCH1, DEC, BRT, FETCH1, DEC, BRN};
        op = 7'b1100011; zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            funct3 = (i < 3) ? 3'b000 : 3'b001;
            mem_ready = 1'b1;
            #1;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL branch cyc%0d obs=%b exp=%b", i, obs, e[i]);
            end
            @(negedge clk);
        end
        zero = 1'b0;
    endtask

    task automatic test_sw();
        logic [18:0] e [6] = '{FETCH1, DEC, ADR_S, MWR0, MWR0, MWR1};
        bit          m [6] = '{1, 1, 1, 0, 0, 1};
        op = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 6; i++) begin
            mem_ready = m[i];
            #1;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL sw cyc%0d obs=%b exp=%b", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0]  ops [6] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011};
        logic [2:0]  f3s [6] = '{3'b000, 3'b010, 3'b110, 3'b000, 3'b111, 3'b001};
        bit          f7s [6] = '{1, 0, 0, 1, 0, 1};
        logic [2:0]  ctl [6] = '{3'b001, 3'b101, 3'b011, 3'b000, 3'b010, 3'b000};
        logic [18:0] e [4];
        for (int k = 0; k < 6; k++) begin
            op = ops[k]; funct3 = f3s[k]; funct7b5 = f7s[k];
            e = '{FETCH1, DEC, (ops[k][4] && !ops[k][5] ? EXI : EXR) | {14'b0, ctl[k], 2'b0}, AWB};
            for (int i = 0; i < 4; i++) begin
                mem_ready = 1'b1;
                #1;
                compared++;
                if (obs !== e[i]) begin
                    mismatched++;
                    $display("FAIL alu%0d cyc%0d obs=%b exp=%b", k, i, obs, e[i]);
                end
                @(negedge clk);
            end
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_jal_lui();
        logic [18:0] e [8] = '{FETCH1, DEC, JALV, AWB, FETCH1, DEC, LUIV, AWB};
        for (int i = 0; i < 8; i++) begin
            op = (i < 4) ? 7'b1101111 : 7'b0110111;
            mem_ready = 1'b1;
            #1;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL jal_lui cyc%0d obs=%b exp=%b", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        logic [18:0] e [14];
        e[0] = FETCH1; e[1] = DEC;
        for (int i = 2; i < 14; i++) e[i] = TRP;
        op = 7'b1111111; zero = 1'b0;
        for (int i = 0; i < 14; i++) begin
            mem_ready = (i < 2) ? 1'b1 : i[0];
            zero = i[1];
            #1;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL trap cyc%0d obs=%b exp=%b", i, obs, e[i]);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1; zero = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (obs !== FETCH0) begin
            mismatched++;
            $display("FAIL trap_reset obs=%b exp=%b", obs, FETCH0);
        end
        rst_n = 1'b1;
        #1;
        compared++;
        if (obs !== FETCH1) begin
            mismatched++;
            $display("FAIL trap_release obs=%b exp=%b", obs, FETCH1);
        end
        op = 7'b0110011; funct3 = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (obs !== (i == 0 ? DEC : i == 1 ? EXR : AWB)) begin
                mismatched++;
                $display("FAIL trap_recover cyc%0d obs=%b", i, obs);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] e [7] = '{FETCH1, DEC, BRT, FETCH1, DEC, EXI, AWB};
        zero = 1'b1; funct3 = 3'b000;
        for (int i = 0; i < 7; i++) begin
            op = (i < 3) ? 7'b1100011 : 7'b0010011;
            mem_ready = 1'b1;
            #1;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL b2b cyc%0d obs=%b exp=%b", i, obs, e[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_branch();
        test_sw();
        test_alu_decode();
        test_jal_lui();
        test_trap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
